// File: rtl/scene_exec_unit_pkg.sv
// Shared types for the scene execution back-end: opcodes, decoded instruction
// layout, camera/light word arrays and geometry entry sizing.
package scene_exec_unit_pkg;

    localparam int INST_WORD_W    = 16;
    localparam int CAM_WORDS      = 8;
    localparam int LIGHT_WORDS    = 4;
    localparam int GEOMETRY_WIDTH = 128;
    localparam int IDX_W          = 8;
    localparam int PROP_W         = 4;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_SET_CAM   = 3'd1,
        OP_SET_LIGHT = 3'd2,
        OP_SET_GEO   = 3'd3,
        OP_RENDER    = 3'd4
    } OpType;

    typedef struct packed {
        OpType                  op;
        logic [IDX_W-1:0]       idx;
        logic [PROP_W-1:0]      prop;
        logic [INST_WORD_W-1:0] data;
    } DecodedInst;

    typedef logic [CAM_WORDS-1:0][INST_WORD_W-1:0]   Camera;
    typedef logic [LIGHT_WORDS-1:0][INST_WORD_W-1:0] Light;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_GEO_RD      = 3'd1,
        ST_GEO_WAIT    = 3'd2,
        ST_GEO_WR      = 3'd3,
        ST_RENDER_WAIT = 3'd4
    } exec_state_e;

endpackage

// File: rtl/scene_exec_unit_geo_bram.sv
// True dual-port read-first geometry RAM with a two-register read pipeline;
// port A is read/write for the executor, port B is the renderer's read port.
module geo_bram_dp #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_a_i,
    input  logic [ADDR_W-1:0] addr_a_i,
    input  logic [WIDTH-1:0]  din_a_i,
    output logic [WIDTH-1:0]  dout_a_o,
    input  logic [ADDR_W-1:0] addr_b_i,
    output logic [WIDTH-1:0]  dout_b_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_a_p1, dout_a_p2;
    logic [WIDTH-1:0] dout_b_p1, dout_b_p2;

    // Port A: array read and write share the edge, so a write returns old data.
    always_ff @(posedge clk_i) begin
        if (we_a_i) begin
            mem[addr_a_i] <= din_a_i;
        end
        dout_a_p1 <= mem[addr_a_i];
        dout_a_p2 <= dout_a_p1;
    end

    // Port B
    always_ff @(posedge clk_i) begin
        dout_b_p1 <= mem[addr_b_i];
        dout_b_p2 <= dout_b_p1;
    end

    assign dout_a_o = dout_a_p2;
    assign dout_b_o = dout_b_p2;

endmodule

// File: rtl/scene_exec_unit.sv
// Applies decoded instructions to camera/light registers and the geometry RAM,
// and runs the render request/done handshake with the rasterizer.
module scene_exec_unit
    import scene_exec_unit_pkg::*;
#(
    parameter int NUM_GEO   = 16,
    parameter int WORD_W    = INST_WORD_W,
    parameter int GEO_WORDS = GEOMETRY_WIDTH / WORD_W
) (
    input  logic                       clk_100mhz,
    input  logic                       rst_n,
    input  logic                       execInst_valid,
    input  DecodedInst                 execInst,
    output logic                       mem_ready,
    output Camera                      cur_camera,
    output Light                       cur_light,
    input  logic [$clog2(NUM_GEO)-1:0] geo_rd_addr,
    output logic [GEOMETRY_WIDTH-1:0]  cur_geo,
    output logic                       render_start,
    input  logic                       render_done
);

    localparam int ADDR_W  = $clog2(NUM_GEO);
    localparam int CAM_AW  = $clog2(CAM_WORDS);
    localparam int LIGHT_AW = $clog2(LIGHT_WORDS);

    exec_state_e         state_q, state_d;
    logic                ready_q, ready_d;
    logic                start_q, start_d;
    Camera               cam_q;
    Light                light_q;
    logic [ADDR_W-1:0]   geo_idx_q, geo_idx_d;
    logic [PROP_W-1:0]   geo_prop_q, geo_prop_d;
    logic [WORD_W-1:0]   geo_data_q, geo_data_d;
    logic                geo_we;
    logic [GEOMETRY_WIDTH-1:0] geo_rd_a, geo_wr_a;

    logic accept, cam_hit, light_hit, geo_in_range;

    assign accept       = execInst_valid && ready_q;
    assign cam_hit      = accept && (execInst.op == OP_SET_CAM)   && (int'(execInst.prop) < CAM_WORDS);
    assign light_hit    = accept && (execInst.op == OP_SET_LIGHT) && (int'(execInst.prop) < LIGHT_WORDS);
    assign geo_in_range = (int'(execInst.idx) < NUM_GEO) && (int'(execInst.prop) < GEO_WORDS);

    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        geo_we     = 1'b0;
        geo_idx_d  = geo_idx_q;
        geo_prop_d = geo_prop_q;
        geo_data_d = geo_data_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (execInst.op)
                        OP_SET_GEO: begin
                            // Out-of-range targets are swallowed as a NOP.
                            if (geo_in_range) begin
                                state_d    = ST_GEO_RD;
                                geo_idx_d  = execInst.idx[ADDR_W-1:0];
                                geo_prop_d = execInst.prop;
                                geo_data_d = execInst.data;
                            end
                        end
                        OP_RENDER: begin
                            state_d = ST_RENDER_WAIT;
                            start_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            ST_GEO_RD:   state_d = ST_GEO_WAIT;
            ST_GEO_WAIT: state_d = ST_GEO_WR;
            ST_GEO_WR: begin
                geo_we  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_RENDER_WAIT: begin
                if (render_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_comb begin
        geo_wr_a = geo_rd_a;
        for (int w = 0; w < GEO_WORDS; w++) begin
            if (int'(geo_prop_q) == w) begin
                geo_wr_a[w*WORD_W +: WORD_W] = geo_data_q;
            end
        end
    end

    // Registered ready keeps mem_ready low through reset and raises it one edge after release.
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            start_q <= 1'b0;
            cam_q   <= '0;
            light_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            start_q <= start_d;
            if (cam_hit) begin
                cam_q[execInst.prop[CAM_AW-1:0]] <= execInst.data;
            end
            if (light_hit) begin
                light_q[execInst.prop[LIGHT_AW-1:0]] <= execInst.data;
            end
        end
    end

    always_ff @(posedge clk_100mhz) begin
        geo_idx_q  <= geo_idx_d;
        geo_prop_q <= geo_prop_d;
        geo_data_q <= geo_data_d;
    end

    geo_bram_dp #(
        .DEPTH  (NUM_GEO),
        .WIDTH  (GEOMETRY_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_bram (
        .clk_i    (clk_100mhz),
        .we_a_i   (geo_we),
        .addr_a_i (geo_idx_q),
        .din_a_i  (geo_wr_a),
        .dout_a_o (geo_rd_a),
        .addr_b_i (geo_rd_addr),
        .dout_b_o (cur_geo)
    );

    assign mem_ready    = ready_q;
    assign render_start = start_q;
    assign cur_camera   = cam_q;
    assign cur_light    = light_q;

endmodule

// File: tb/tb_scene_exec_unit.sv
// Directed bench for scene_exec_unit: camera/light writes, geometry RMW,
// out-of-range handling, render handshake and reset during an RMW.
module tb_scene_exec_unit;
    import scene_exec_unit_pkg::*;

    localparam int NUM_GEO = 16;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       execInst_valid;
    DecodedInst                 execInst;
    logic                       mem_ready;
    Camera                      cur_camera;
    Light                       cur_light;
    logic [$clog2(NUM_GEO)-1:0] geo_rd_addr;
    logic [GEOMETRY_WIDTH-1:0]  cur_geo;
    logic                       render_start;
    logic                       render_done;

    int n_cmp = 0;
    int n_err = 0;

    scene_exec_unit #(.NUM_GEO(NUM_GEO)) dut (
        .clk_100mhz     (clk),
        .rst_n          (rst_n),
        .execInst_valid (execInst_valid),
        .execInst       (execInst),
        .mem_ready      (mem_ready),
        .cur_camera     (cur_camera),
        .cur_light      (cur_light),
        .geo_rd_addr    (geo_rd_addr),
        .cur_geo        (cur_geo),
        .render_start   (render_start),
        .render_done    (render_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic DecodedInst mk(input OpType op, input int idx, input int prop, input logic [15:0] data);
        DecodedInst d;
        d.op   = op;
        d.idx  = 8'(idx);
        d.prop = 4'(prop);
        d.data = data;
        return d;
    endfunction

    initial begin
        logic [127:0] cam_exp;
        cam_exp = 128'h0000_0000_0000_0000_0000_1234_0000_0000;

        rst_n          = 1'b0;
        execInst_valid = 1'b0;
        execInst       = mk(OP_NOP, 0, 0, 16'h0);
        geo_rd_addr    = '0;
        render_done    = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", mem_ready, 0);
        chk("rst_start", render_start, 0);
        chk("rst_cam", cur_camera, 0);
        chk("rst_light", cur_light, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_release", mem_ready, 1);

        // Camera write
        execInst_valid = 1'b1;
        execInst       = mk(OP_SET_CAM, 0, 2, 16'h1234);
        tick();
        execInst_valid = 1'b0;
        chk("cam_word2", cur_camera, cam_expected(cam_exp));

        // Light back-to-back
        for (int p = 0; p < 4; p++) begin
            execInst_valid = 1'b1;
            execInst       = mk(OP_SET_LIGHT, 0, p, 16'hA0 + 16'(p));
            chk("light_ready", mem_ready, 1);
            tick();
        end
        chk("light_all", cur_light, 64'h00A3_00A2_00A1_00A0);
        execInst = mk(OP_SET_LIGHT, 0, 5, 16'hFFFF);
        tick();
        execInst_valid = 1'b0;
        chk("light_oob", cur_light, 64'h00A3_00A2_00A1_00A0);

        // Geometry RMW on entry 3, words 0 then 1
        execInst_valid = 1'b1;
        execInst       = mk(OP_SET_GEO, 3, 0, 16'hBEEF);
        chk("geo0_ready_pre", mem_ready, 1);
        tick();
        execInst_valid = 1'b0;
        chk("geo0_busy1", mem_ready, 0);
        tick();
        chk("geo0_busy2", mem_ready, 0);
        tick();
        chk("geo0_busy3", mem_ready, 0);
        chk("geo0_we", dut.geo_we, 1);
        tick();
        chk("geo0_ready_post", mem_ready, 1);

        execInst_valid = 1'b1;
        execInst       = mk(OP_SET_GEO, 3, 1, 16'hCAFE);
        tick();
        execInst_valid = 1'b0;
        chk("geo1_busy1", mem_ready, 0);
        tick();
        chk("geo1_busy2", mem_ready, 0);
        tick();
        chk("geo1_busy3", mem_ready, 0);
        tick();
        chk("geo1_ready_post", mem_ready, 1);

        geo_rd_addr = 4'd3;
        tick();
        tick();
        chk("geo_readback", cur_geo[31:0], 32'hCAFEBEEF);

        // Out-of-range idx, then out-of-range prop
        execInst_valid = 1'b1;
        execInst       = mk(OP_SET_GEO, NUM_GEO, 0, 16'h5555);
        tick();
        execInst_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("oob_idx_ready", mem_ready, 1);
            chk("oob_idx_we", dut.geo_we, 0);
            tick();
        end
        execInst_valid = 1'b1;
        execInst       = mk(OP_SET_GEO, 3, 8, 16'h5555);
        tick();
        execInst_valid = 1'b0;
        chk("oob_prop_ready", mem_ready, 1);
        chk("oob_prop_we", dut.geo_we, 0);
        tick();
        chk("geo_after_oob", cur_geo[31:0], 32'hCAFEBEEF);

        // Render handshake with a competing instruction held during the wait
        execInst_valid = 1'b1;
        execInst       = mk(OP_RENDER, 0, 0, 16'h0);
        tick();
        chk("render_start_hi", render_start, 1);
        chk("render_ready_lo", mem_ready, 0);
        execInst = mk(OP_SET_CAM, 0, 0, 16'h7777);
        tick();
        chk("render_start_lo", render_start, 0);
        for (int c = 0; c < 10; c++) begin
            chk("render_wait_ready", mem_ready, 0);
            tick();
        end
        render_done = 1'b1;
        tick();
        render_done    = 1'b0;
        execInst_valid = 1'b0;
        chk("render_ready_back", mem_ready, 1);
        chk("render_cam_untouched", cur_camera, cam_expected(cam_exp));
        tick();
        chk("render_start_still_lo", render_start, 0);

        // Seed entry 5, then reset during the next RMW's GEO_WAIT
        execInst_valid = 1'b1;
        execInst       = mk(OP_SET_GEO, 5, 0, 16'h1111);
        tick();
        execInst_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("seed_ready", mem_ready, 1);
        execInst_valid = 1'b1;
        execInst       = mk(OP_SET_GEO, 5, 0, 16'h2222);
        tick();
        execInst_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrmw_ready", mem_ready, 0);
        chk("midrmw_start", render_start, 0);
        chk("midrmw_cam", cur_camera, 0);
        chk("midrmw_light", cur_light, 0);
        chk("midrmw_we", dut.geo_we, 0);
        tick();
        chk("midrmw_we_held", dut.geo_we, 0);
        tick();
        rst_n = 1'b1;
        geo_rd_addr = 4'd5;
        tick();
        chk("midrmw_ready_back", mem_ready, 1);
        tick();
        tick();
        chk("midrmw_entry_old", cur_geo[15:0], 16'h1111);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic [127:0] cam_expected(input logic [127:0] v);
        return v;
    endfunction

endmodule
